// File: rtl/led_bank_ctrl.sv
// led_bank_ctrl: memory-mapped LED bank controller.
//
// Drives LED_W board LEDs from a DATA_W-bit bus using lane-addressed writes.
// The register map is selected by led_addr[3:2]: 0 VALUE, 1 BLINK, 2 CTRL,
// 3 reserved. led_addr[1:0] selects the lane. The block also provides
// per-LED blink, global PWM brightness and registered readback.
//
// Optional feature macro: LED_BLINK_EN. When it is defined, the BLINK
// registers and the blink timer are built in. When it is undefined, BLINK
// accesses behave as reserved.
//
// Parameters:
//   LED_W     number of LEDs (1..64)
//   DATA_W    bus width; ceil(LED_W/DATA_W) must be <= 4 and DATA_W >= PWM_BITS
//   BLINK_DIV clk cycles per blink half-period (>= 2)
//   PWM_BITS  brightness resolution (1..8)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   led_cs     access strobe, one access per asserted cycle
//   led_we     1 = write, 0 = read (qualified by led_cs)
//   led_addr   [3:2] register class, [1:0] lane
//   led_wdata  write data
//   led_rdata  registered read data, holds between reads
//   led_rvalid one-cycle pulse qualifying led_rdata
//   ledout     registered LED drive, 1 = lit
module led_bank_ctrl #(
  parameter int unsigned LED_W     = 24,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned PWM_BITS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              led_cs,
  input  logic              led_we,
  input  logic [3:0]        led_addr,
  input  logic [DATA_W-1:0] led_wdata,
  output logic [DATA_W-1:0] led_rdata,
  output logic              led_rvalid,
  output logic [LED_W-1:0]  ledout
);

  typedef enum logic [1:0] {ClsValue, ClsBlink, ClsCtrl, ClsRsvd} reg_class_e;

  reg_class_e reg_class;
  logic [1:0] lane;

  assign reg_class = reg_class_e'(led_addr[3:2]);
  assign lane      = led_addr[1:0];

  // LED bit i lives in lane i/DATA_W at position i%DATA_W. Lanes at or above
  // NLANES match no bit, so such writes fall away and such reads give 0.
  // Bits past LED_W-1 in the top lane are dropped in the same way.
  function automatic logic [LED_W-1:0] lane_write(input logic [LED_W-1:0]  old,
                                                  input logic [1:0]        sel,
                                                  input logic [DATA_W-1:0] wdata);
    logic [LED_W-1:0] res;
    res = old;
    for (int unsigned i = 0; i < LED_W; i++) begin
      if (sel == 2'(i / DATA_W)) res[i] = wdata[i % DATA_W];
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] lane_read(input logic [LED_W-1:0] regv,
                                                  input logic [1:0]       sel);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      if (sel == 2'(i / DATA_W)) res[i % DATA_W] = regv[i];
    end
    return res;
  endfunction

  logic [LED_W-1:0]    value_q, value_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LED_W-1:0]    ledout_q, ledout_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                pwm_on;

`ifdef LED_BLINK_EN
  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [LED_W-1:0] blink_q, blink_d;
  logic [CntW-1:0]  blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == CntW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end
`endif

  // Duty all-ones is forced on so that full brightness has no dark slot.
  assign pwm_on    = (duty_q == '1) || (pwm_cnt_q < duty_q);
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;

  always_comb begin
`ifdef LED_BLINK_EN
    ledout_d = value_q & (~blink_q | {LED_W{phase_q}}) & {LED_W{pwm_on}};
`else
    ledout_d = value_q & {LED_W{pwm_on}};
`endif
  end

  // Register access decode. Reads see pre-write contents because the state
  // registers only update at the edge.
  always_comb begin
    value_d  = value_q;
    duty_d   = duty_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
`ifdef LED_BLINK_EN
    blink_d  = blink_q;
`endif
    if (led_cs) begin
      if (led_we) begin
        unique case (reg_class)
          ClsValue: value_d = lane_write(value_q, lane, led_wdata);
`ifdef LED_BLINK_EN
          ClsBlink: blink_d = lane_write(blink_q, lane, led_wdata);
`endif
          ClsCtrl:  duty_d  = led_wdata[PWM_BITS-1:0];
          default:  ;
        endcase
      end else begin
        rvalid_d = 1'b1;
        rdata_d  = '0;
        unique case (reg_class)
          ClsValue: rdata_d = lane_read(value_q, lane);
`ifdef LED_BLINK_EN
          ClsBlink: rdata_d = lane_read(blink_q, lane);
`endif
          ClsCtrl:  rdata_d[PWM_BITS-1:0] = duty_q;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q   <= '0;
      duty_q    <= '1;
      pwm_cnt_q <= '0;
      ledout_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      value_q   <= value_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      ledout_q  <= ledout_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

`ifdef LED_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`endif

  assign ledout     = ledout_q;
  assign led_rdata  = rdata_q;
  assign led_rvalid = rvalid_q;

endmodule
